// File: rtl/fresh_prng_d2.sv
// Fresh-randomness source for masked S-boxes: seeded 64-bit LFSR, FRESH_WIDTH steps per advance.
// Latency: en -> new word in 1 cycle, seed -> first valid word after WARMUP_CYCLES+1 edges; never stalls on its own.
module fresh_prng_d2 #(
    parameter int FRESH_WIDTH     = 63,
    parameter int WARMUP_CYCLES   = 4,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_valid,
    input  logic [63:0]            seed,
    output logic                   seed_ready,
    input  logic                   en,
    output logic [FRESH_WIDTH-1:0] Fresh,
    output logic                   fresh_valid,
    output logic                   reseed_req
);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} fsm_t;

    localparam logic [31:0] WARM_LAST = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0] USE_LIMIT = 32'(RESEED_INTERVAL);

    fsm_t        fsm;
    logic [63:0] state;
    logic [31:0] warm_cnt;
    logic [31:0] use_cnt;
    logic [63:0] state_adv;
    logic [63:0] seed_load;
    logic        seed_hs;

    // x^64+x^63+x^61+x^60+1, unrolled FRESH_WIDTH times so each advance yields fully fresh bits
    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < FRESH_WIDTH; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    assign state_adv = advance(state);
    assign seed_load = (seed == 64'd0) ? 64'd1 : seed;
    assign seed_hs   = seed_valid && seed_ready;
    assign Fresh     = state[FRESH_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            state       <= 64'd0;
            warm_cnt    <= 32'd0;
            use_cnt     <= 32'd0;
            seed_ready  <= 1'b1;
            fresh_valid <= 1'b0;
            reseed_req  <= 1'b0;
        end else if (seed_hs) begin
            // A seed wins over en: load only, no advance and no usage count.
            fsm         <= WARMUP;
            state       <= seed_load;
            warm_cnt    <= 32'd0;
            use_cnt     <= 32'd0;
            seed_ready  <= 1'b0;
            fresh_valid <= 1'b0;
            reseed_req  <= 1'b0;
        end else begin
            case (fsm)
                WARMUP: begin
                    state    <= state_adv;
                    warm_cnt <= warm_cnt + 32'd1;
                    if (warm_cnt == WARM_LAST) begin
                        fsm         <= RUN;
                        seed_ready  <= 1'b1;
                        fresh_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (en) begin
                        state <= state_adv;
                        if (use_cnt != USE_LIMIT) begin
                            use_cnt <= use_cnt + 32'd1;
                        end
                        if (use_cnt == USE_LIMIT - 32'd1) begin
                            reseed_req <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fresh_prng_d2.sv
// Bench for fresh_prng_d2: directed scenarios plus random traffic against a bit-serial reference model.
module tb_fresh_prng_d2;
    localparam int FW = 63;
    localparam int WU = 4;
    localparam int RI = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seed_valid = 1'b0;
    logic [63:0]   seed = 64'd0;
    logic          en = 1'b0;
    logic          seed_ready;
    logic [FW-1:0] Fresh;
    logic          fresh_valid;
    logic          reseed_req;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [63:0] m_s      = 64'd0;
    int          m_warm   = 0;
    bit          m_seeded = 1'b0;
    int          m_used   = 0;
    bit          m_req    = 1'b0;

    fresh_prng_d2 #(
        .FRESH_WIDTH    (FW),
        .WARMUP_CYCLES  (WU),
        .RESEED_INTERVAL(RI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .en         (en),
        .Fresh      (Fresh),
        .fresh_valid(fresh_valid),
        .reseed_req (reseed_req)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_steps(input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
        return s;
    endfunction

    function automatic logic [FW+2:0] exp_outs();
        bit fv;
        bit sr;
        fv = m_seeded && (m_warm == 0);
        sr = !m_seeded || (m_warm == 0);
        return {m_s[FW-1:0], fv, sr, m_req};
    endfunction

    // Updates the model from the inputs presented this cycle, then clocks the DUT.
    task automatic tick();
        bit sr;
        sr = !m_seeded || (m_warm == 0);
        if (rst) begin
            m_s = 64'd0; m_warm = 0; m_seeded = 1'b0; m_used = 0; m_req = 1'b0;
        end else if (seed_valid && sr) begin
            m_s = (seed == 64'd0) ? 64'd1 : seed;
            m_warm = WU; m_seeded = 1'b1; m_used = 0; m_req = 1'b0;
        end else if (m_seeded && m_warm > 0) begin
            m_s = lfsr_steps(m_s, FW);
            m_warm--;
        end else if (m_seeded && en) begin
            m_s = lfsr_steps(m_s, FW);
            if (m_used < RI) m_used++;
            if (m_used == RI) m_req = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_warm(input logic [63:0] s);
        en = 1'b0;
        seed = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        repeat (WU) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({Fresh, fresh_valid, seed_ready, reseed_req} !== {63'd0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outs got=%h exp=%h", {Fresh, fresh_valid, seed_ready, reseed_req},
                     {63'd0, 1'b0, 1'b1, 1'b0});
        end
        total++;
        if (dut.use_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_use_cnt got=%0d exp=0", dut.use_cnt);
        end
    endtask

    task automatic test_seed();
        logic [63:0] s0;
        logic [63:0] ref_s;
        s0 = 64'h0123_4567_89AB_CDEF;
        ref_s = lfsr_steps(s0, WU * FW);
        seed = s0;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        seed = {$urandom, $urandom};
        total++;
        if (seed_ready !== 1'b0) begin
            bad++;
            $display("FAIL seed_ready_drop got=%b exp=0", seed_ready);
        end
        for (int k = 0; k <= WU; k++) begin
            if (k > 0) tick();
            total++;
            if (fresh_valid !== (k == WU)) begin
                bad++;
                $display("FAIL seed_fresh_valid cycle=%0d got=%b exp=%b", k, fresh_valid, (k == WU));
            end
            total++;
            if ({Fresh, fresh_valid, seed_ready, reseed_req} !== exp_outs()) begin
                bad++;
                $display("FAIL seed_model cycle=%0d got=%h exp=%h", k,
                         {Fresh, fresh_valid, seed_ready, reseed_req}, exp_outs());
            end
        end
        total++;
        if (Fresh !== ref_s[FW-1:0]) begin
            bad++;
            $display("FAIL seed_first_word got=%h exp=%h", Fresh, ref_s[FW-1:0]);
        end
    endtask

    task automatic test_zero_seed();
        logic [FW-1:0] seq0[10];
        load_and_warm(64'd0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            seq0[i] = Fresh;
            total++;
            if (Fresh === '0) begin
                bad++;
                $display("FAIL zero_seed_stuck word=%0d got=%h exp=nonzero", i, Fresh);
            end
            tick();
        end
        load_and_warm(64'd1);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (Fresh !== seq0[i]) begin
                bad++;
                $display("FAIL zero_seed_seq word=%0d got=%h exp=%h", i, Fresh, seq0[i]);
            end
            tick();
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        logic [FW-1:0] prev;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        load_and_warm({$urandom, $urandom});
        for (int i = 0; i < 4; i++) begin
            prev = Fresh;
            en = pat[i];
            tick();
            total++;
            if ((Fresh !== prev) !== pat[i]) begin
                bad++;
                $display("FAIL stall_change step=%0d got=%h prev=%h exp_change=%b", i, Fresh, prev, pat[i]);
            end
            total++;
            if ({Fresh, fresh_valid, seed_ready, reseed_req} !== exp_outs()) begin
                bad++;
                $display("FAIL stall_model step=%0d got=%h exp=%h", i,
                         {Fresh, fresh_valid, seed_ready, reseed_req}, exp_outs());
            end
        end
        en = 1'b0;
        total++;
        if (dut.use_cnt !== 32'd2) begin
            bad++;
            $display("FAIL stall_use_cnt got=%0d exp=2", dut.use_cnt);
        end
    endtask

    task automatic test_budget();
        logic [FW-1:0] prev;
        load_and_warm({$urandom, $urandom});
        en = 1'b1;
        for (int w = 1; w <= RI + 4; w++) begin
            prev = Fresh;
            tick();
            total++;
            if (reseed_req !== (w >= RI)) begin
                bad++;
                $display("FAIL budget_req word=%0d got=%b exp=%b", w, reseed_req, (w >= RI));
            end
            total++;
            if (Fresh === prev) begin
                bad++;
                $display("FAIL budget_advance word=%0d got=%h exp=changed", w, Fresh);
            end
        end
        en = 1'b0;
        seed = {$urandom, $urandom};
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        total++;
        if (reseed_req !== 1'b0) begin
            bad++;
            $display("FAIL budget_req_clear got=%b exp=0", reseed_req);
        end
        for (int k = 0; k <= WU; k++) begin
            if (k > 0) tick();
            total++;
            if (fresh_valid !== (k == WU)) begin
                bad++;
                $display("FAIL budget_reseed_valid cycle=%0d got=%b exp=%b", k, fresh_valid, (k == WU));
            end
        end
    endtask

    task automatic test_collision();
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] ref_s;
        s1 = {$urandom, $urandom} | 64'h1;
        s2 = {$urandom, $urandom} | 64'h2;
        ref_s = lfsr_steps(s1, WU * FW);
        seed = s1;
        seed_valid = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        total++;
        if ({Fresh, fresh_valid} !== {s1[FW-1:0], 1'b0}) begin
            bad++;
            $display("FAIL collision_seed_wins got=%h exp=%h", {Fresh, fresh_valid}, {s1[FW-1:0], 1'b0});
        end
        seed = s2;
        for (int k = 1; k <= WU; k++) begin
            seed_valid = (k < WU);
            tick();
        end
        total++;
        if ({Fresh, fresh_valid} !== {ref_s[FW-1:0], 1'b1}) begin
            bad++;
            $display("FAIL collision_warmup_ignore got=%h exp=%h", {Fresh, fresh_valid}, {ref_s[FW-1:0], 1'b1});
        end
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        total++;
        if ({Fresh, fresh_valid} !== {s2[FW-1:0], 1'b0}) begin
            bad++;
            $display("FAIL collision_run_accept got=%h exp=%h", {Fresh, fresh_valid}, {s2[FW-1:0], 1'b0});
        end
    endtask

    task automatic test_midwarm_reset();
        seed = {$urandom, $urandom};
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({Fresh, fresh_valid, seed_ready, reseed_req} !== {63'd0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midwarm_reset got=%h exp=%h", {Fresh, fresh_valid, seed_ready, reseed_req},
                     {63'd0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            seed_valid = ($urandom_range(0, 11) == 0);
            seed = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
            en = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if ({Fresh, fresh_valid, seed_ready, reseed_req} !== exp_outs()) begin
                bad++;
                $display("FAIL random_model cycle=%0d got=%h exp=%h", i,
                         {Fresh, fresh_valid, seed_ready, reseed_req}, exp_outs());
            end
        end
        rst = 1'b0;
        seed_valid = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seed();
        test_zero_seed();
        test_stall();
        test_budget();
        test_collision();
        test_midwarm_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
